// File: rtl/wb_scoreboard_pkg.sv
// wb_scoreboard_pkg: shared CPU writeback types and constants.
package wb_scoreboard_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NREGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    return NREGS'(1) << r;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order synchronous FIFO of arbitrary entry type, no empty bypass.
module wb_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           do_push, do_pop;

  always_comb begin
    full_o  = cnt_q == CW'(DEPTH);
    empty_o = cnt_q == '0;
    do_push = push_i & !full_o;
    do_pop  = pop_i & !empty_o;
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: merges ALU and queued long-latency results onto the register
// file write port and tracks busy destinations of outstanding long ops.
module wb_scoreboard #(
  parameter int XLEN     = wb_scoreboard_pkg::XLEN,
  parameter int LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_lng_issue,
  input  logic [4:0]      i_lng_issue_rd,
  input  logic            i_lng_valid,
  output logic            o_lng_ready,
  input  logic [4:0]      i_lng_rd,
  input  logic [XLEN-1:0] i_lng_data,
  input  logic [4:0]      i_chk_rs1,
  input  logic [4:0]      i_chk_rs2,
  input  logic [4:0]      i_chk_rd,
  output logic            o_hazard,
  output logic [31:0]     o_busy,
  output logic            o_wr_en,
  output logic [4:0]      o_wr_addr,
  output logic [XLEN-1:0] o_wr_data
);
  import wb_scoreboard_pkg::*;

  localparam int CW = $clog2(LQ_DEPTH) + 1;

  wb_entry_t         head, lng_in;
  logic              full, empty, acc, push, pop;
  logic [CW-1:0]     count;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;
  logic [NREGS-1:0]  busy_q, busy_d, set_m, clr_m;

  wb_fifo #(.DEPTH(LQ_DEPTH), .T(wb_entry_t)) u_lq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (lng_in),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign o_lng_ready = !full;

  // ALU owns the port whenever valid, even with rd==0, so the queue waits.
  always_comb begin
    lng_in.rd   = i_lng_rd;
    lng_in.data = i_lng_data;
    acc         = i_lng_valid & o_lng_ready;
    push        = acc & (i_lng_rd != '0);
    pop         = !empty & !i_alu_valid;
    wr_en_d     = i_alu_valid ? (i_alu_rd != '0) : pop;
    wr_addr_d   = i_alu_valid ? i_alu_rd : head.rd;
    wr_data_d   = i_alu_valid ? i_alu_data : head.data;
    set_m       = (i_lng_issue && i_lng_issue_rd != '0) ? reg_onehot(i_lng_issue_rd) : '0;
    clr_m       = pop ? reg_onehot(head.rd) : '0;
    busy_d      = ((busy_q & ~clr_m) | set_m) & ~NREGS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_busy    = busy_q;
  assign o_hazard  = busy_q[i_chk_rs1] | busy_q[i_chk_rs2] | busy_q[i_chk_rd];

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(i_alu_valid && i_alu_rd != '0 && busy_q[i_alu_rd]))
        else $error("ALU write to busy register x%0d", i_alu_rd);
      assert (!(i_lng_issue && i_lng_issue_rd != '0 && busy_q[i_lng_issue_rd]))
        else $error("long op issued to busy register x%0d", i_lng_issue_rd);
      assert (!(acc && i_lng_rd != '0 && !busy_q[i_lng_rd]))
        else $error("long result for non-busy register x%0d", i_lng_rd);
      assert (count <= CW'(LQ_DEPTH))
        else $error("queue occupancy overflow %0d", count);
    end
  end
`endif
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: directed and randomized checks against a queue-based model.
module tb_wb_scoreboard;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_v, iss, lv;
  logic [4:0]  alu_rd, iss_rd, lrd, rs1, rs2, crd;
  logic [31:0] alu_d, ld;
  logic        o_lng_ready, o_hazard, o_wr_en;
  logic [31:0] o_busy, o_wr_data;
  logic [4:0]  o_wr_addr;

  wb_scoreboard #(.XLEN(32), .LQ_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_alu_valid    (alu_v),
    .i_alu_rd       (alu_rd),
    .i_alu_data     (alu_d),
    .i_lng_issue    (iss),
    .i_lng_issue_rd (iss_rd),
    .i_lng_valid    (lv),
    .o_lng_ready    (o_lng_ready),
    .i_lng_rd       (lrd),
    .i_lng_data     (ld),
    .i_chk_rs1      (rs1),
    .i_chk_rs2      (rs2),
    .i_chk_rd       (crd),
    .o_hazard       (o_hazard),
    .o_busy         (o_busy),
    .o_wr_en        (o_wr_en),
    .o_wr_addr      (o_wr_addr),
    .o_wr_data      (o_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          ostd[$];
  logic [31:0] mb = '0;
  logic        e_en = 1'b0;
  logic [4:0]  e_a = '0;
  logic [31:0] e_d = '0;
  logic        acc = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cyc();
    logic rdy;
    ent_t e;
    #2;
    rdy = mq.size() < DEPTH;
    chk("lng_ready", o_lng_ready, rdy);
    chk("hazard", o_hazard, mb[rs1] | mb[rs2] | mb[crd]);
    @(posedge clk);
    e_en = 1'b0;
    if (alu_v) begin
      if (alu_rd != 0) begin e_en = 1'b1; e_a = alu_rd; e_d = alu_d; end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      e_en = 1'b1; e_a = e.rd; e_d = e.d;
      mb[e.rd] = 1'b0;
    end
    if (iss && iss_rd != 0) mb[iss_rd] = 1'b1;
    acc = lv && rdy;
    if (acc && lrd != 0) mq.push_back('{lrd, ld});
    #1;
    chk("wr_en", o_wr_en, e_en);
    if (e_en) begin
      chk("wr_addr", o_wr_addr, e_a);
      chk("wr_data", o_wr_data, e_d);
    end
    chk("busy", o_busy, mb);
  endtask

  task automatic idle();
    alu_v = 1'b0; iss = 1'b0; lv = 1'b0;
  endtask

  function automatic logic [4:0] pick(input logic [4:0] avoid, input logic use_avoid);
    logic [4:0] r;
    for (int t = 0; t < 64; t++) begin
      r = 5'($urandom);
      if (!mb[r] && !(use_avoid && r == avoid)) return r;
    end
    return 5'd0;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    alu_rd = '0; alu_d = '0; iss_rd = '0; lrd = '0; ld = '0;
    rs1 = '0; rs2 = '0; crd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", o_wr_en, 1'b0);
    chk("rst_wr_addr", o_wr_addr, 5'd0);
    chk("rst_wr_data", o_wr_data, 32'd0);
    chk("rst_busy", o_busy, 32'd0);
    chk("rst_ready", o_lng_ready, 1'b1);
    rst_n = 1'b1;

    // ALU write, then ALU rd=0
    alu_v = 1'b1; alu_rd = 5'd5; alu_d = 32'hDEADBEEF; cyc();
    alu_v = 1'b0; cyc();
    alu_v = 1'b1; alu_rd = 5'd0; alu_d = 32'h11111111; cyc();
    alu_v = 1'b0; cyc();

    // Long op to x7 with hazard check on rs2
    iss = 1'b1; iss_rd = 5'd7; cyc();
    iss = 1'b0; rs2 = 5'd7; cyc();
    lv = 1'b1; lrd = 5'd7; ld = 32'h00001234; cyc();
    chk("x7_accepted", acc, 1'b1);
    lv = 1'b0; cyc(); cyc(); cyc();
    rs2 = 5'd0;

    // ALU burst holds off queued x9
    iss = 1'b1; iss_rd = 5'd9; cyc();
    iss = 1'b0; lv = 1'b1; lrd = 5'd9; ld = 32'h99990009; cyc();
    lv = 1'b0; crd = 5'd9;
    for (int i = 0; i < 4; i++) begin
      alu_v = 1'b1; alu_rd = 5'(i + 2); alu_d = 32'hA000_0000 + 32'(i); cyc();
    end
    alu_v = 1'b0; cyc(); cyc(); cyc();
    crd = 5'd0;

    // Full queue with ALU busy, third result held off
    iss = 1'b1; iss_rd = 5'd10; cyc();
    iss_rd = 5'd11; cyc();
    iss_rd = 5'd12; cyc();
    iss = 1'b0;
    alu_v = 1'b1; alu_rd = 5'd1; alu_d = 32'h0000_0001;
    lv = 1'b1; lrd = 5'd10; ld = 32'hAAAA_000A; cyc();
    lrd = 5'd11; ld = 32'hBBBB_000B; cyc();
    lrd = 5'd12; ld = 32'hCCCC_000C; cyc(); cyc();
    alu_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (acc) break;
    end
    chk("x12_accepted", acc, 1'b1);
    lv = 1'b0;
    repeat (4) cyc();

    // rd=0 issue and result
    iss = 1'b1; iss_rd = 5'd0; cyc();
    iss = 1'b0; lv = 1'b1; lrd = 5'd0; ld = 32'h0BAD_0BAD; cyc();
    chk("rd0_accepted", acc, 1'b1);
    lv = 1'b0; cyc(); cyc();

    // Asynchronous reset with two queued entries and x7 busy
    iss = 1'b1; iss_rd = 5'd7; cyc();
    iss_rd = 5'd13; cyc();
    iss = 1'b0; alu_v = 1'b1; alu_rd = 5'd3; alu_d = 32'h3333_3333;
    lv = 1'b1; lrd = 5'd7; ld = 32'h7777_7777; cyc();
    lrd = 5'd13; ld = 32'hDDDD_DDDD; cyc();
    lv = 1'b0; cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", o_wr_en, 1'b0);
    chk("midrst_busy", o_busy, 32'd0);
    chk("midrst_ready", o_lng_ready, 1'b1);
    mq.delete(); mb = '0; e_en = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) cyc();

    // Randomized legal traffic
    for (int n = 0; n < 400; n++) begin
      iss = ($urandom % 3) == 0;
      iss_rd = pick(5'd0, 1'b0);
      alu_v = 1'($urandom % 2);
      alu_rd = pick(iss_rd, iss);
      alu_d = $urandom;
      if (!lv) begin
        if (ostd.size() > 0 && ($urandom % 2) == 1) begin
          int idx;
          idx = int'($urandom % ostd.size());
          lrd = 5'(ostd[idx]);
          ostd.delete(idx);
          lv = 1'b1; ld = $urandom;
        end else if (($urandom % 8) == 0) begin
          lv = 1'b1; lrd = 5'd0; ld = $urandom;
        end
      end
      rs1 = 5'($urandom); rs2 = 5'($urandom); crd = 5'($urandom);
      cyc();
      if (acc) lv = 1'b0;
      if (iss && iss_rd != 0) ostd.push_back(int'(iss_rd));
    end
    alu_v = 1'b0; iss = 1'b0;
    repeat (10) begin
      cyc();
      if (acc) lv = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
